// File: rtl/rgb_led_arbiter.sv
// Frame-synchronous RGB LED ownership arbiter with shadowed PWM duties and blink gating.
// Define RGB_ARB_ROUND_ROBIN_EN to select round-robin winners instead of fixed priority.
module rgb_led_arbiter #(
    parameter int N_REQ           = 4,
    parameter int PWM_BITS        = 8,
    parameter int MIN_HOLD_FRAMES = 4,
    parameter int BLINK_FRAMES    = 32
) (
    input  logic                        hw_clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            blink,
    input  logic [N_REQ*3*PWM_BITS-1:0] color,
    output logic [N_REQ-1:0]            grant,
    output logic                        led_en,
    output logic                        pwm_red,
    output logic                        pwm_green,
    output logic                        pwm_blue
);
    localparam int CW = 3 * PWM_BITS;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MIN_HOLD_FRAMES + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [HW-1:0]       HOLD_MIN   = HW'(MIN_HOLD_FRAMES);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
    logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
    logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
    logic                blink_q, blink_d;
    logic                phase_on_q, phase_on_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                led_en_q, led_en_d;
    logic                pwm_r_q, pwm_r_d;
    logic                pwm_g_q, pwm_g_d;
    logic                pwm_b_q, pwm_b_d;

    logic          frame_end;
    logic          own;
    logic          cand_v;
    logic          comp_v;
    logic          pwm_active;
    logic [IW-1:0] cand;
    logic [CW-1:0] col_sel;

    assign frame_end = (cnt_q == CNT_MAX);
    assign own       = (state_q == S_OWN);

    // Candidate is the best active requester other than the current owner.
    always_comb begin
        cand_v = 1'b0;
        cand   = '0;
`ifdef RGB_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!cand_v && req[i] && (!own || i > int'(owner_q))) begin
                cand_v = 1'b1;
                cand   = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!cand_v && req[i] && !(own && i == int'(owner_q))) begin
                cand_v = 1'b1;
                cand   = IW'(i);
            end
        end
        comp_v = cand_v;
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!cand_v && req[i] && !(own && i == int'(owner_q))) begin
                cand_v = 1'b1;
                cand   = IW'(i);
            end
        end
        comp_v = cand_v && (cand < owner_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        if (frame_end) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cand_v) begin
                        state_d = S_OWN;
                        owner_d = cand;
                        hold_d  = HW'(1);
                    end
                end
                S_OWN: begin
                    if (!req[owner_q]) begin
                        if (cand_v) begin
                            owner_d = cand;
                            hold_d  = HW'(1);
                        end else begin
                            state_d = S_IDLE;
                            hold_d  = '0;
                        end
                    end else if (hold_q < HOLD_MIN) begin
                        hold_d = hold_q + HW'(1);
                    end else if (comp_v) begin
                        owner_d = cand;
                        hold_d  = HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are computed for the upcoming cycle so the registers line up with cnt.
    always_comb begin
        cnt_d      = cnt_q + PWM_BITS'(1);
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;
        blink_d    = blink_q;
        phase_on_d = phase_on_q;
        bcnt_d     = bcnt_q;
        col_sel    = color[int'(owner_d)*CW +: CW];
        if (frame_end) begin
            if (state_d == S_OWN) begin
                duty_r_d = col_sel[CW-1 -: PWM_BITS];
                duty_g_d = col_sel[2*PWM_BITS-1 -: PWM_BITS];
                duty_b_d = col_sel[PWM_BITS-1:0];
                blink_d  = blink[owner_d];
            end else begin
                duty_r_d = '0;
                duty_g_d = '0;
                duty_b_d = '0;
                blink_d  = 1'b0;
            end
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d     = '0;
                phase_on_d = !phase_on_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
        pwm_active = (state_d == S_OWN) && !(blink_d && !phase_on_d);
        pwm_r_d    = pwm_active && (cnt_d < duty_r_d);
        pwm_g_d    = pwm_active && (cnt_d < duty_g_d);
        pwm_b_d    = pwm_active && (cnt_d < duty_b_d);
        grant_d    = '0;
        if (state_d == S_OWN) begin
            grant_d[owner_d] = 1'b1;
        end
        led_en_d = (state_d == S_OWN);
    end

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= '0;
            hold_q     <= '0;
            duty_r_q   <= '0;
            duty_g_q   <= '0;
            duty_b_q   <= '0;
            blink_q    <= 1'b0;
            phase_on_q <= 1'b1;
            bcnt_q     <= '0;
            grant_q    <= '0;
            led_en_q   <= 1'b0;
            pwm_r_q    <= 1'b0;
            pwm_g_q    <= 1'b0;
            pwm_b_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            blink_q    <= blink_d;
            phase_on_q <= phase_on_d;
            bcnt_q     <= bcnt_d;
            grant_q    <= grant_d;
            led_en_q   <= led_en_d;
            pwm_r_q    <= pwm_r_d;
            pwm_g_q    <= pwm_g_d;
            pwm_b_q    <= pwm_b_d;
        end
    end

    assign grant     = grant_q;
    assign led_en    = led_en_q;
    assign pwm_red   = pwm_r_q;
    assign pwm_green = pwm_g_q;
    assign pwm_blue  = pwm_b_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: vector table, directed corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_rgb_led_arbiter;
    localparam int N     = 4;
    localparam int PB    = 4;
    localparam int MH    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 16;

    logic        hw_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  req    = '0;
    logic [3:0]  blink  = '0;
    logic [47:0] color  = '0;
    logic [3:0]  grant;
    logic        led_en;
    logic        pwm_red;
    logic        pwm_green;
    logic        pwm_blue;

    int checks   = 0;
    int failures = 0;

    always #5 hw_clk = ~hw_clk;

    rgb_led_arbiter #(
        .N_REQ(N),
        .PWM_BITS(PB),
        .MIN_HOLD_FRAMES(MH),
        .BLINK_FRAMES(BF)
    ) dut (
        .hw_clk(hw_clk),
        .rst(rst),
        .req(req),
        .blink(blink),
        .color(color),
        .grant(grant),
        .led_en(led_en),
        .pwm_red(pwm_red),
        .pwm_green(pwm_green),
        .pwm_blue(pwm_blue)
    );

    // Frame-level reference: owner, hold, latched duties, frame index.
    int   m_cnt = 0;
    int   m_owner = -1;
    int   m_hold = 0;
    int   m_frame = 0;
    int   m_duty[3] = '{0, 0, 0};
    logic m_blink = 1'b0;
    bit   m_valid = 1'b0;

    function automatic int pick(input logic [3:0] r, input int cur);
        int w;
        w = -1;
`ifdef RGB_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (cur < 0) ? (k - 1) : (cur + k) % N;
            if (w < 0 && r[i] && i != cur) w = i;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i] && i != cur) w = i;
        end
`endif
        return w;
    endfunction

    function automatic void model_step();
        int w;
        bit comp;
        logic [11:0] c;
        if (rst) begin
            m_cnt = 0;
            m_owner = -1;
            m_hold = 0;
            m_frame = 0;
            m_duty = '{0, 0, 0};
            m_blink = 1'b0;
            m_valid = 1'b1;
            return;
        end
        if (m_cnt == FRAME - 1) begin
            if (m_owner < 0) begin
                w = pick(req, -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_hold = 1;
                end
            end else if (!req[m_owner]) begin
                w = pick(req, m_owner);
                m_owner = w;
                m_hold = (w >= 0) ? 1 : 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end else begin
                w = pick(req, m_owner);
`ifdef RGB_ARB_ROUND_ROBIN_EN
                comp = (w >= 0);
`else
                comp = (w >= 0) && (w < m_owner);
`endif
                if (comp) begin
                    m_owner = w;
                    m_hold = 1;
                end
            end
            if (m_owner >= 0) begin
                c = color[m_owner*12 +: 12];
                m_duty[0] = int'(c[11:8]);
                m_duty[1] = int'(c[7:4]);
                m_duty[2] = int'(c[3:0]);
                m_blink = blink[m_owner];
            end else begin
                m_duty = '{0, 0, 0};
                m_blink = 1'b0;
            end
            m_frame++;
        end
        m_cnt = (m_cnt + 1) % FRAME;
    endfunction

    function automatic logic [7:0] exp_out();
        logic on;
        logic act;
        logic [7:0] e;
        on = ((m_frame / BF) % 2) == 0;
        act = (m_owner >= 0) && !(m_blink && !on);
        e[7:4] = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e[3] = (m_owner >= 0);
        e[2] = act && (m_cnt < m_duty[0]);
        e[1] = act && (m_cnt < m_duty[1]);
        e[0] = act && (m_cnt < m_duty[2]);
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge hw_clk);
        model_step();
        #1;
        if (m_valid) begin
            check("model", int'({grant, led_en, pwm_red, pwm_green, pwm_blue}),
                  int'(exp_out()));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic count_frame(output int r, output int g, output int b, output int l);
        r = 0;
        g = 0;
        b = 0;
        l = 0;
        for (int i = 0; i < FRAME; i++) begin
            r += int'(pwm_red);
            g += int'(pwm_green);
            b += int'(pwm_blue);
            l += int'(led_en);
            tick();
        end
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [47:0] col;
        logic [3:0]  gnt;
        logic        led;
        int          r;
        int          g;
        int          b;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int r, g, b, l;
        localparam logic [47:0] CA = 48'hF00_0F0_00F_5A3;

        tbl[0] = '{4'b0001, CA, 4'b0001, 1'b1, 5, 10, 3};
        tbl[1] = '{4'b0010, CA, 4'b0010, 1'b1, 0, 0, 15};
        tbl[2] = '{4'b0110, CA, 4'b0010, 1'b1, 0, 0, 15};
        tbl[3] = '{4'b1100, CA, 4'b0100, 1'b1, 0, 15, 0};
        tbl[4] = '{4'b1000, CA, 4'b1000, 1'b1, 15, 0, 0};
        tbl[5] = '{4'b0000, CA, 4'b0000, 1'b0, 0, 0, 0};
        tbl[6] = '{4'b0001, 48'h000_000_000_FFF, 4'b0001, 1'b1, 15, 15, 15};
        tbl[7] = '{4'b0001, 48'h000_000_000_000, 4'b0001, 1'b1, 0, 0, 0};
        tbl[8] = '{4'b1011, 48'h000_000_888_123, 4'b0001, 1'b1, 1, 2, 3};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            req = tbl[i].rq;
            color = tbl[i].col;
            blink = '0;
            repeat (2 * FRAME) tick();
            check("tbl_grant", int'(grant), int'(tbl[i].gnt));
            check("tbl_led", int'(led_en), int'(tbl[i].led));
            count_frame(r, g, b, l);
            check("tbl_red", r, tbl[i].r);
            check("tbl_green", g, tbl[i].g);
            check("tbl_blue", b, tbl[i].b);
        end

        // Reset and single request
        do_reset();
        req = '0;
        color = '0;
        repeat (3) tick();
        req = 4'b0010;
        color = 48'h000_000_50F_000;
        repeat (12) tick();
        check("s1_grant_c15", int'(grant), 0);
        tick();
        check("s1_grant_c16", int'(grant), 2);
        check("s1_led", int'(led_en), 1);
        count_frame(r, g, b, l);
        check("s1_red", r, 5);
        check("s1_green", g, 0);
        check("s1_blue", b, 15);
        check("s1_led_cnt", l, 16);

        // Preemption with minimum hold
        do_reset();
        req = 4'b1000;
        color = 48'h111_222_333_444;
        repeat (16) tick();
        check("s2_own3", int'(grant), 8);
        repeat (4) tick();
        req = 4'b1001;
        repeat (27) tick();
        check("s2_hold_c47", int'(grant), 8);
        tick();
        check("s2_switch_c48", int'(grant), 1);

        // Owner release mid-frame
        do_reset();
        req = 4'b0100;
        color = 48'h000_FFF_000_000;
        repeat (20) tick();
        req = '0;
        repeat (10) tick();
        check("s3_red_c30", int'(pwm_red), 1);
        check("s3_grant_c30", int'(grant), 4);
        tick();
        check("s3_grant_c31", int'(grant), 4);
        check("s3_led_c31", int'(led_en), 1);
        tick();
        check("s3_grant_c32", int'(grant), 0);
        check("s3_led_c32", int'(led_en), 0);
        check("s3_pwm_c32", int'({pwm_red, pwm_green, pwm_blue}), 0);

        // Blink
        do_reset();
        req = 4'b0001;
        blink = 4'b0001;
        color = 48'h000_000_000_FFF;
        repeat (16) tick();
        for (int f = 1; f <= 7; f++) begin
            count_frame(r, g, b, l);
            check("s4_blink_red", r, ((f / 2) % 2 == 0) ? 15 : 0);
            check("s4_blink_blue", b, ((f / 2) % 2 == 0) ? 15 : 0);
            check("s4_blink_led", l, 16);
        end
        blink = '0;

        // Mid-frame colour change, then mid-frame reset
        do_reset();
        req = 4'b0001;
        color = 48'h000_000_000_400;
        repeat (16) tick();
        count_frame(r, g, b, l);
        check("s5_red_f1", r, 4);
        repeat (7) tick();
        color = 48'h000_000_000_A00;
        r = 0;
        for (int i = 0; i < 9; i++) begin
            r += int'(pwm_red);
            tick();
        end
        check("s5_red_f2_tail", r, 0);
        count_frame(r, g, b, l);
        check("s5_red_f3", r, 10);
        repeat (9) tick();
        check("s5_red_c73", int'(pwm_red), 1);
        rst = 1'b1;
        tick();
        check("s5_rst_grant", int'(grant), 0);
        check("s5_rst_led", int'(led_en), 0);
        check("s5_rst_red", int'(pwm_red), 0);
        rst = 1'b0;
        repeat (15) tick();
        check("s5_post_c15", int'(grant), 0);
        tick();
        check("s5_post_c16", int'(grant), 1);
        check("s5_post_red", int'(pwm_red), 1);

        // All requesters held
        do_reset();
        req = 4'b1111;
        color = CA;
        repeat (16) tick();
        for (int f = 1; f <= 8; f++) begin
            repeat (8) tick();
`ifdef RGB_ARB_ROUND_ROBIN_EN
            check("s6_all_req", int'(grant), 1 << (((f - 1) / 2) % 4));
`else
            check("s6_all_req", int'(grant), 1);
`endif
            repeat (8) tick();
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 15) == 0) req = 4'($urandom());
            if ($urandom_range(0, 31) == 0) blink = 4'($urandom());
            if ($urandom_range(0, 47) == 0) color = 48'({$urandom(), $urandom()});
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the single on-chip RGB LED driver between up to N_REQ status requesters (heartbeat, error, activity, etc.). It arbitrates ownership on PWM frame boundaries, enforces a minimum hold time, and generates the three PWM bits and enable that feed the SB_RGBA_DRV primitive (RGB0PWM=red, RGB1PWM=blue, RGB2PWM=green, RGBLEDEN/CURREN). It sits between the requester logic and the RGB driver instance in the top level, clocked from the internal oscillator domain.

## Interface
- N_REQ, 4, number of requesters; index 0 is highest priority.
- PWM_BITS, 8, PWM counter width; frame length is 2^PWM_BITS cycles.
- MIN_HOLD_FRAMES, 4, minimum frames an owner keeps the grant while requesting; must be ≥1.
- BLINK_FRAMES, 32, frames per blink half-period; must be ≥1.

- hw_clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester.
- blink  in  N_REQ  requester i wants its colour blinked.
- color  in  N_REQ*3*PWM_BITS  requester i colour at [i*3*PWM_BITS +: 3*PWM_BITS], ordered {red,green,blue}, each a duty value.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- led_en  out  1  high while any grant is active; drives RGBLEDEN/CURREN.
- pwm_red / pwm_green / pwm_blue  out  1 each  PWM bits to the driver.

## Operation
- Free-running frame counter cnt, 0..2^PWM_BITS-1, wraps. frame_end is the cycle where cnt is at its maximum.
- All arbitration, duty shadowing and blink-phase updates happen only at the frame_end edge. Nothing changes mid-frame.
- FSM states:
  - IDLE: grant=0, led_en=0, PWM outputs 0.
  - OWN: exactly one grant bit set.
- Transitions at frame_end:
  - IDLE, any req → OWN with the winner; hold=1. No req → stay IDLE.
  - OWN, owner req low → winner among the remaining reqs (hold=1), or IDLE if none.
  - OWN, owner req high, hold<MIN_HOLD_FRAMES → stay; hold+1.
  - OWN, owner req high, hold≥MIN_HOLD_FRAMES:
    - switch to a competing winner if one exists (hold=1).
    - otherwise stay; hold saturates.
- Default winner rule (fixed priority): lowest active index. A competitor counts only if its index is lower than the owner's.
- Duty shadowing: at each frame_end the new owner's three duties are latched into shadow registers. Colour input changes mid-frame take effect the next frame.
- PWM: during a frame, pwm_x is high in the cycle where cnt=c iff c < shadow duty_x.
  - duty 0 → never high.
  - duty max → high 2^PWM_BITS-1 cycles per frame.
- Blink phase: a free-running frame counter toggles phase every BLINK_FRAMES frames. Phase resets to ON.
  - If the owner's blink bit is latched set at frame_end and phase is OFF, all pwm_x are 0 for that frame.
  - led_en stays high during an OFF blink frame.
- Owner dropping req mid-frame: grant and outputs persist until frame_end.
- Simultaneous requests: resolved purely by the winner rule.

## Timing
- Reset: cnt=0, grant=0, led_en=0, pwm_*=0, hold=0, blink phase ON, FSM=IDLE.
- The first frame starts at cnt=0 in the first cycle after rst deasserts.
- rst asserted mid-frame: state returns to reset values on the next edge. No partial frame completes.
- Request-to-grant latency: grant, led_en and shadow duties update at the frame_end edge and are valid from cnt=0 of the next frame.
  - Latency is 1 to 2^PWM_BITS cycles after req is sampled high.
- PWM outputs are registered. pwm_x for cnt=c is visible in the cycle cnt=c; there is no extra skew between channels.
- grant, led_en and pwm_* are glitch-free register outputs.

## Configuration
- RGB_ARB_ROUND_ROBIN_EN defined:
  - The winner is the first active req searching upward from owner+1, wrapping; from IDLE, the search starts at index 0.
  - After MIN_HOLD_FRAMES, any other active req counts as a competitor.
- Undefined: fixed priority exactly as in Operation.

## Test plan
All scenarios use bench parameters PWM_BITS=4 (16-cycle frame), MIN_HOLD_FRAMES=2, BLINK_FRAMES=2.
- Reset and single request:
  - Stimulus: reset, then req=0b0010 with colour1 {r=5,g=0,b=15} at cycle 3.
  - Response: grant=0b0010 from cycle 16. pwm_red high exactly 5 cycles per frame, pwm_green never, pwm_blue 15 cycles. led_en=1.
- Priority preemption with hold:
  - Stimulus: owner req3 granted, then req0 asserts.
  - Response: grant stays 0b1000 until owner hold reaches 2 frames, then switches to 0b0001 at the following frame_end.
- Owner release:
  - Stimulus: sole owner drops req mid-frame.
  - Response: outputs continue to frame_end, then grant=0, led_en=0, pwm all 0.
- Blink:
  - Stimulus: owner with blink=1 and colour {15,15,15}.
  - Response: pwm toggles between 2 frames active and 2 frames all-zero. led_en stays 1.
- Mid-frame colour change and reset:
  - Stimulus: change owner duty 4→10 at cnt=7, then assert rst at cnt=9 of a later frame.
  - Response: the new duty appears only from the next frame. On reset, all outputs are 0 the next cycle and cnt restarts at 0.
- Round robin (with RGB_ARB_ROUND_ROBIN_EN):
  - Stimulus: req=0b1111 held.
  - Response: grant cycles 0001→0010→0100→1000→0001, each held 2 frames.
